router_output_arbiter: RTL and testbench
========================================

ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 Parameter NUM_PORTS, default 5, requester count (0=Local,1=North,2=East,3=South,4=West).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  NUM_PORTS  per-requester flit valid.
REQ-006 in_data  input  NUM_PORTS*DATA_WIDTH  per-requester flit; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_tail  input  NUM_PORTS  per-requester last-flit-of-packet marker.
REQ-008 in_ready  output  NUM_PORTS  per-requester flit accepted this cycle when valid and ready.
REQ-009 out_valid  output  1  flit presented downstream.
REQ-010 out_data  output  DATA_WIDTH  flit downstream.
REQ-011 out_tail  output  1  tail marker downstream.
REQ-012 out_ready  input  1  downstream can accept a flit.
REQ-013 grant  output  NUM_PORTS  one-hot current owner; all-zero when unlocked.
REQ-014 busy  output  1  high while locked to a requester.
REQ-015 pkt_count  output  16  completed-packet counter.

Function
REQ-016 The block SHALL implement two states: IDLE and LOCKED.
REQ-017 In IDLE, in_ready SHALL be all-zero, out_valid 0, grant all-zero, busy 0.
REQ-018 In IDLE with any in_valid bit set, the block SHALL select the first requester with in_valid=1 searching upward from rr_ptr, wrapping from NUM_PORTS-1 to 0, register it as owner, and enter LOCKED on the next edge.
REQ-019 In IDLE with no in_valid bit set, state, rr_ptr and grant SHALL be held.
REQ-020 Arbitration latency SHALL be exactly one cycle: first flit can transfer no earlier than the cycle after in_valid is first seen in IDLE.
REQ-021 In LOCKED, out_valid, out_data, out_tail SHALL combinationally equal the owner's in_valid, in_data slice, in_tail; grant SHALL be one-hot on owner; busy 1.
REQ-022 In LOCKED, in_ready[owner] SHALL equal out_ready; all other in_ready bits SHALL be 0.
REQ-023 out_valid SHALL never depend on out_ready.
REQ-024 A transfer SHALL occur in any LOCKED cycle with out_valid=1 and out_ready=1.
REQ-025 On a transfer with out_tail=1, the block SHALL return to IDLE, set rr_ptr to (owner+1) mod NUM_PORTS, and increment pkt_count by 1 modulo 2^16.
REQ-026 On a transfer with out_tail=0, or no transfer, the block SHALL remain LOCKED on the same owner.
REQ-027 Owner deasserting in_valid mid-packet SHALL NOT release the lock; out_valid drops to 0 and the lock persists indefinitely.
REQ-028 Requests from non-owners while LOCKED SHALL be ignored and not alter rr_ptr.
REQ-029 A single-flit packet (tail on first flit) SHALL occupy IDLE->LOCKED->IDLE, minimum 2 cycles.
REQ-030 After any tail transfer the block SHALL spend at least one cycle in IDLE (one bubble between packets).
REQ-031 rr_ptr SHALL be ceil(log2(NUM_PORTS)) bits and only take values 0..NUM_PORTS-1.

Reset
REQ-032 While rst=1 at a rising edge: state IDLE, rr_ptr 0, owner 0, pkt_count 0; consequently in_ready 0, out_valid 0, grant 0, busy 0.
REQ-033 Reset asserted mid-packet SHALL drop the lock without completing the packet and without incrementing pkt_count; rst SHALL take priority over any simultaneous transfer.

Verification
REQ-034 After reset, in_valid=5'b00100 with 3-flit packet (tail on 3rd), out_ready=1 -> grant=5'b00100 from cycle 2, three flits out on consecutive cycles, then IDLE, rr_ptr=3, pkt_count=1.
REQ-035 rr_ptr=0, all five in_valid=1 continuously, single-flit packets -> grant order 0,1,2,3,4,0 with one IDLE bubble between each; pkt_count=6 after six packets.
REQ-036 Locked on port 1, out_ready=0 for 4 cycles with owner valid -> out_valid=1, out_data stable, in_ready all-zero for 4 cycles, no pkt_count change.
REQ-037 Locked on port 3, owner drops in_valid for 2 cycles mid-packet while port 0 requests -> out_valid=0, grant stays 5'b01000, port 0 in_ready=0.
REQ-038 rst=1 during 2nd flit of a 4-flit packet with simultaneous transfer -> next cycle IDLE, grant 0, pkt_count unchanged at 0, rr_ptr=0.
REQ-039 pkt_count=16'hFFFF then one tail transfer -> pkt_count=16'h0000.

Source files
------------

// File: rtl/router_output_arbiter.sv
// Router output-port arbiter.
// Wormhole-style lock: once a requester wins, it owns the output until its
// tail flit transfers. Winner selection is round-robin starting at rr_ptr,
// which moves to the port after the last owner when a packet completes.
module router_output_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_PORTS-1:0]             in_tail,
    output logic [NUM_PORTS-1:0]             in_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_tail,
    input  logic                             out_ready,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy,
    output logic [15:0]                      pkt_count
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [15:0]        pkt_count_q, pkt_count_d;
    logic [PTR_W-1:0]   pick;
    logic               pick_found;
    int                 idx;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        pick       = rr_ptr_q;
        pick_found = 1'b0;
        idx        = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!pick_found && in_valid[idx]) begin
                pick       = PTR_W'(idx);
                pick_found = 1'b1;
            end
        end
    end

    // Next-state logic and the owner-steered datapath outputs.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        pkt_count_d = pkt_count_q;
        in_ready    = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_tail    = 1'b0;
        grant       = '0;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                busy              = 1'b1;
                grant[owner_q]    = 1'b1;
                out_valid         = in_valid[owner_q];
                out_data          = in_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
                out_tail          = in_tail[owner_q];
                in_ready[owner_q] = out_ready;
                // Only a transferred tail flit releases the lock.
                if (out_valid && out_ready && out_tail) begin
                    state_d     = IDLE;
                    pkt_count_d = pkt_count_q + 16'd1;
                    if (owner_q == PTR_W'(NUM_PORTS - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = owner_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset wins over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed testbench for router_output_arbiter with hand-computed expectations.
module tb_router_output_arbiter;

    localparam int DW = 32;
    localparam int NP = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NP-1:0]       in_valid;
    logic [NP*DW-1:0]    in_data;
    logic [NP-1:0]       in_tail;
    logic [NP-1:0]       in_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_tail;
    logic                out_ready;
    logic [NP-1:0]       grant;
    logic                busy;
    logic [15:0]         pkt_count;

    int assertCount = 0;
    int failCount   = 0;

    router_output_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tail   (in_tail),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tail  (out_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NP-1:0] v, input logic [NP-1:0] t, input logic r);
        in_valid  = v;
        in_tail   = t;
        out_ready = r;
        #1;
    endtask

    task automatic setFlit(input int p, input logic [DW-1:0] value);
        in_data[p*DW +: DW] = value;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus('0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = '0;
        in_tail   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        doReset();
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
        checkOutput("rst_pkt_count", 32'(pkt_count), 32'h0);

        // Three-flit packet on port 2
        setFlit(2, 32'hC2C2_0000);
        applyStimulus(5'b00100, 5'b00000, 1'b1);
        checkOutput("p2_idle_grant", 32'(grant), 32'h0);
        checkOutput("p2_idle_in_ready", 32'(in_ready), 32'h0);
        tick();
        checkOutput("p2_f0_grant", 32'(grant), 32'h04);
        checkOutput("p2_f0_busy", 32'(busy), 32'h1);
        checkOutput("p2_f0_data", 32'(out_data), 32'hC2C2_0000);
        checkOutput("p2_f0_in_ready", 32'(in_ready), 32'h04);
        checkOutput("p2_f0_tail", 32'(out_tail), 32'h0);
        tick();
        setFlit(2, 32'hC2C2_0001);
        #1;
        checkOutput("p2_f1_data", 32'(out_data), 32'hC2C2_0001);
        checkOutput("p2_f1_grant", 32'(grant), 32'h04);
        tick();
        setFlit(2, 32'hC2C2_0002);
        applyStimulus(5'b00100, 5'b00100, 1'b1);
        checkOutput("p2_f2_data", 32'(out_data), 32'hC2C2_0002);
        checkOutput("p2_f2_tail", 32'(out_tail), 32'h1);
        tick();
        applyStimulus('0, '0, 1'b1);
        checkOutput("p2_done_busy", 32'(busy), 32'h0);
        checkOutput("p2_done_grant", 32'(grant), 32'h0);
        checkOutput("p2_done_pkt", 32'(pkt_count), 32'h1);
        checkOutput("p2_done_rr", 32'(dut.rr_ptr_q), 32'h3);

        // Round-robin rotation of single-flit packets from all ports
        doReset();
        for (int i = 0; i < NP; i++) begin
            setFlit(i, 32'h1000 + 32'(i));
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus(5'b11111, 5'b11111, 1'b1);
            checkOutput($sformatf("rr_bubble%0d", k), 32'(busy), 32'h0);
            tick();
            checkOutput($sformatf("rr_grant%0d", k), 32'(grant), 32'h1 << (k % NP));
            checkOutput($sformatf("rr_data%0d", k), 32'(out_data), 32'h1000 + 32'(k % NP));
            tick();
        end
        checkOutput("rr_pkt6", 32'(pkt_count), 32'h6);

        // Backpressure while locked on port 1
        setFlit(1, 32'hBEEF_0001);
        applyStimulus(5'b00010, 5'b00000, 1'b0);
        checkOutput("bp_idle_busy", 32'(busy), 32'h0);
        tick();
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("bp_out_valid%0d", c), 32'(out_valid), 32'h1);
            checkOutput($sformatf("bp_data%0d", c), 32'(out_data), 32'hBEEF_0001);
            checkOutput($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'h0);
            checkOutput($sformatf("bp_grant%0d", c), 32'(grant), 32'h02);
            checkOutput($sformatf("bp_pkt%0d", c), 32'(pkt_count), 32'h6);
            tick();
        end
        applyStimulus(5'b00010, 5'b00010, 1'b1);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'h02);
        tick();
        applyStimulus('0, '0, 1'b1);
        checkOutput("bp_done_busy", 32'(busy), 32'h0);
        checkOutput("bp_done_pkt", 32'(pkt_count), 32'h7);
        checkOutput("bp_done_rr", 32'(dut.rr_ptr_q), 32'h2);

        // Owner on port 3 stalls mid-packet while port 0 requests
        setFlit(3, 32'h3333_0000);
        applyStimulus(5'b01000, 5'b00000, 1'b1);
        tick();
        checkOutput("st_f0_grant", 32'(grant), 32'h08);
        checkOutput("st_f0_out_valid", 32'(out_valid), 32'h1);
        tick();
        applyStimulus(5'b00001, 5'b00000, 1'b1);
        for (int c = 0; c < 2; c++) begin
            checkOutput($sformatf("st_out_valid%0d", c), 32'(out_valid), 32'h0);
            checkOutput($sformatf("st_grant%0d", c), 32'(grant), 32'h08);
            checkOutput($sformatf("st_in_ready%0d", c), 32'(in_ready), 32'h08);
            checkOutput($sformatf("st_busy%0d", c), 32'(busy), 32'h1);
            tick();
        end
        setFlit(3, 32'h3333_0001);
        applyStimulus(5'b01001, 5'b01000, 1'b1);
        checkOutput("st_tail_data", 32'(out_data), 32'h3333_0001);
        checkOutput("st_tail_flag", 32'(out_tail), 32'h1);
        tick();
        checkOutput("st_done_busy", 32'(busy), 32'h0);
        checkOutput("st_done_pkt", 32'(pkt_count), 32'h8);
        checkOutput("st_done_rr", 32'(dut.rr_ptr_q), 32'h4);
        setFlit(0, 32'h0000_AAAA);
        applyStimulus(5'b00001, 5'b00001, 1'b1);
        tick();
        checkOutput("wrap_grant", 32'(grant), 32'h01);
        checkOutput("wrap_data", 32'(out_data), 32'h0000_AAAA);
        tick();
        applyStimulus('0, '0, 1'b1);
        checkOutput("wrap_pkt", 32'(pkt_count), 32'h9);
        checkOutput("wrap_rr", 32'(dut.rr_ptr_q), 32'h1);

        // Reset during the 2nd flit of a 4-flit packet, transfer in progress
        doReset();
        checkOutput("mr_pkt_start", 32'(pkt_count), 32'h0);
        setFlit(2, 32'h2222_0000);
        applyStimulus(5'b00100, 5'b00000, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("mr_xfer_valid", 32'(out_valid), 32'h1);
        tick();
        rst = 1'b0;
        applyStimulus('0, '0, 1'b0);
        checkOutput("mr_grant", 32'(grant), 32'h0);
        checkOutput("mr_busy", 32'(busy), 32'h0);
        checkOutput("mr_pkt", 32'(pkt_count), 32'h0);
        checkOutput("mr_rr", 32'(dut.rr_ptr_q), 32'h0);

        // Reset coincident with a tail transfer: no packet counted
        applyStimulus(5'b00100, 5'b00100, 1'b1);
        tick();
        checkOutput("rt_locked", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus('0, '0, 1'b0);
        checkOutput("rt_pkt", 32'(pkt_count), 32'h0);
        checkOutput("rt_rr", 32'(dut.rr_ptr_q), 32'h0);

        // Packet counter wraps from 16'hFFFF to 16'h0000
        force dut.pkt_count_q = 16'hFFFF;
        #1;
        release dut.pkt_count_q;
        #1;
        checkOutput("wr_pkt_preset", 32'(pkt_count), 32'hFFFF);
        applyStimulus(5'b00100, 5'b00100, 1'b1);
        tick();
        tick();
        applyStimulus('0, '0, 1'b0);
        checkOutput("wr_pkt_wrap", 32'(pkt_count), 32'h0);
        checkOutput("wr_rr", 32'(dut.rr_ptr_q), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
